// File: rtl/prime_tally_pkg.sv
// prime_pkg: shared types and helpers for the prime tally block.
//   state_e    - tally FSM state encoding
//   BCD_W      - bits per BCD digit
//   digits_max - largest value representable in nd decimal digits (10^nd - 1)
package prime_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CONV  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int BCD_W = 4;

  function automatic longint unsigned digits_max(input int nd);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < nd; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/prime_tally_if.sv
// prime_tally_if: control, RAM read port and result bundle of the prime tally.
//   start      - sieve-complete level
//   rd_addr    - RAM read address (tally -> RAM)
//   rd_data    - RAM read data, 1 = prime (RAM -> tally)
//   busy, done - tally status
//   prime_cnt  - number of primes found
//   bcd, ovf   - packed BCD of prime_cnt and its overflow flag
// Modport master is the tally side, slave is the sieve/RAM/display side.
interface prime_tally_if
  import prime_pkg::*;
#(
  parameter int AW = 20,
  parameter int CW = 20,
  parameter int ND = 6
);
  logic                  start;
  logic [AW-1:0]         rd_addr;
  logic                  rd_data;
  logic                  busy;
  logic                  done;
  logic [CW-1:0]         prime_cnt;
  logic [BCD_W*ND-1:0]   bcd;
  logic                  ovf;

  modport master (
    input  start, rd_data,
    output rd_addr, busy, done, prime_cnt, bcd, ovf
  );

  modport slave (
    output start, rd_data,
    input  rd_addr, busy, done, prime_cnt, bcd, ovf
  );
endinterface

// File: rtl/prime_tally_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary to packed BCD converter.
//   clk_i, rst_i - clock, synchronous active-high reset
//   start_i      - load bin_i and begin (ignored while busy)
//   bin_i        - CW-bit binary input
//   busy_o       - conversion in progress (CW cycles after the load cycle)
//   done_o       - high in the final conversion cycle; bcd_o/ovf_o valid then
//   bcd_o        - ND packed BCD digits, all 9s when the input does not fit
//   ovf_o        - input >= 10^ND
module bin2bcd_seq
  import prime_pkg::*;
#(
  parameter int CW = 20,
  parameter int ND = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [CW-1:0]       bin_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [BCD_W*ND-1:0] bcd_o,
  output logic                ovf_o
);
  localparam int              CNTW = $clog2(CW + 1);
  localparam longint unsigned DMAX = digits_max(ND);

  logic                busy_q, busy_d;
  logic [CW-1:0]       sh_q, sh_d;
  logic [BCD_W*ND-1:0] work_q, work_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [BCD_W*ND-1:0] adj;
  logic [BCD_W*ND-1:0] step;

  // One double-dabble step. Digits above ND are dropped; they only matter
  // when the value overflows, and that case is replaced by all 9s.
  always_comb begin
    adj = work_q;
    for (int i = 0; i < ND; i++) begin
      if (adj[i*BCD_W +: BCD_W] >= 4'd5)
        adj[i*BCD_W +: BCD_W] = adj[i*BCD_W +: BCD_W] + 4'd3;
    end
    step = {adj[BCD_W*ND-2:0], sh_q[CW-1]};
  end

  always_comb begin
    busy_d = busy_q;
    sh_d   = sh_q;
    work_d = work_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (busy_q) begin
      work_d = step;
      sh_d   = sh_q << 1;
      cnt_d  = cnt_q - CNTW'(1);
      if (cnt_q == CNTW'(1)) busy_d = 1'b0;
    end else if (start_i) begin
      busy_d = 1'b1;
      sh_d   = bin_i;
      work_d = '0;
      cnt_d  = CNTW'(CW);
      ovf_d  = 64'(bin_i) > DMAX;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      sh_q   <= '0;
      work_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      sh_q   <= sh_d;
      work_q <= work_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == CNTW'(1));
  assign bcd_o  = ovf_q ? {ND{4'h9}} : step;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/prime_tally.sv
// prime_tally: counts set entries of the sieve prime-flag RAM over addresses
// 2..N-1 and presents the count in binary and packed BCD.
//   clk_i, rst_i - clock, synchronous active-high reset
//   bus (master) - start level, RAM read port, busy/done, prime_cnt, bcd, ovf
//
// state | meaning
// IDLE  | waiting for start; last result held
// SCAN  | issuing one RAM address per cycle, 2..N-1
// DRAIN | RD_LAT cycles collecting reads still in flight
// CONV  | binary-to-BCD conversion of the final count
// DONE  | result valid; waits for start to drop
module prime_tally
  import prime_pkg::*;
#(
  parameter int N      = 1000000,
  parameter int AW     = 20,
  parameter int CW     = 20,
  parameter int ND     = 6,
  parameter int RD_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  prime_tally_if.master bus
);
  localparam logic [AW-1:0] FIRST = AW'(2);
  localparam logic [AW-1:0] LAST  = AW'((N > 2) ? (N - 1) : 2);
  localparam int            DW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e              state_q, state_d;
  logic [AW-1:0]       rd_addr_q, rd_addr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BCD_W*ND-1:0] bcd_q, bcd_d;
  logic                ovf_q, ovf_d;
  logic [RD_LAT-1:0]   vld_q, vld_d;
  logic [DW-1:0]       drain_q, drain_d;

  logic                conv_start;
  logic                conv_busy;
  logic                conv_done;
  logic [BCD_W*ND-1:0] conv_bcd;
  logic                conv_ovf;

  bin2bcd_seq #(
    .CW (CW),
    .ND (ND)
  ) u_conv (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (conv_start),
    .bin_i   (cnt_q),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd),
    .ovf_o   (conv_ovf)
  );

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    drain_d    = drain_q;
    conv_start = 1'b0;
    // Valid tag per issued address; the oldest tag lines up with rd_data.
    vld_d      = vld_q << 1;
    vld_d[0]   = (state_q == ST_SCAN);

    // Count independent of state so the last return lands even on the cycle
    // the final address is issued; saturate rather than wrap.
    if (vld_q[RD_LAT-1] && bus.rd_data && (cnt_q != '1))
      cnt_d = cnt_q + CW'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          cnt_d = '0;
          if (N > 2) begin
            state_d   = ST_SCAN;
            rd_addr_d = FIRST;
          end else begin
            state_d = ST_CONV;
          end
        end
      end
      ST_SCAN: begin
        if (rd_addr_q == LAST) begin
          state_d = ST_DRAIN;
          drain_d = DW'(RD_LAT - 1);
        end else begin
          rd_addr_d = rd_addr_q + AW'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) state_d = ST_CONV;
        else               drain_d = drain_q - DW'(1);
      end
      ST_CONV: begin
        conv_start = !conv_busy;
        if (conv_done) begin
          bcd_d   = conv_bcd;
          ovf_d   = conv_ovf;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!bus.start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      rd_addr_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      vld_q     <= '0;
      drain_q   <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      vld_q     <= vld_d;
      drain_q   <= drain_d;
    end
  end

  assign bus.rd_addr   = rd_addr_q;
  assign bus.busy      = (state_q == ST_SCAN) || (state_q == ST_DRAIN) || (state_q == ST_CONV);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.prime_cnt = cnt_q;
  assign bus.bcd       = bcd_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_prime_tally.sv
// Testbench for prime_tally: several parameterisations side by side, each
// with its own RAM model and address-sweep monitor.
module tb_prime_tally;
  localparam int NI = 8;
  //                          0   1   2   3  4   5   6    7
  localparam int P_N [NI] = '{32, 100, 16, 16, 2, 32, 40, 200};
  localparam int P_L [NI] = '{1,  1,   1,  2,  1, 1,  1,  3};
  localparam int P_CW[NI] = '{20, 20,  20, 20, 20, 20, 4,  8};
  localparam int P_ND[NI] = '{6,  6,   6,  6,  6, 1,  6,  2};
  localparam int RI = 7;   // instance used for random RAM contents

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v   [NI];
  logic        start_v [NI];
  logic        mem_v   [NI][256];
  logic        done_v  [NI];
  logic        busy_v  [NI];
  logic        ovf_v   [NI];
  logic [31:0] cnt_v   [NI];
  logic [31:0] bcd_v   [NI];
  logic [31:0] addr_v  [NI];
  int          issued_v[NI];
  int          aerr_v  [NI];

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    prime_tally_if #(.AW(20), .CW(P_CW[g]), .ND(P_ND[g])) bus ();

    prime_tally #(
      .N(P_N[g]), .AW(20), .CW(P_CW[g]), .ND(P_ND[g]), .RD_LAT(P_L[g])
    ) dut (
      .clk_i (clk),
      .rst_i (rst_v[g]),
      .bus   (bus)
    );

    // RAM with RD_LAT cycles from address to data
    logic dl [P_L[g]];
    always @(posedge clk) begin
      dl[0] <= mem_v[g][bus.rd_addr[7:0]];
      for (int i = 1; i < P_L[g]; i++) dl[i] <= dl[i-1];
    end
    assign bus.rd_data = dl[P_L[g]-1];
    assign bus.start   = start_v[g];

    assign done_v[g] = bus.done;
    assign busy_v[g] = bus.busy;
    assign ovf_v[g]  = bus.ovf;
    assign cnt_v[g]  = 32'(bus.prime_cnt);
    assign bcd_v[g]  = 32'(bus.bcd);
    assign addr_v[g] = 32'(bus.rd_addr);

    // Address sweep monitor: while busy the address must start at 2, step by
    // one, and may only repeat once it has reached N-1.
    int   issued = 0;
    int   aerr   = 0;
    logic in_run = 1'b0;
    int   prev   = 0;
    always @(negedge clk) begin
      int a;
      a = int'(bus.rd_addr);
      if (P_N[g] > 2 && bus.busy) begin
        if (a < 2 || a > P_N[g] - 1) aerr = aerr + 1;
        if (!in_run) begin
          in_run = 1'b1;
          issued = 1;
          if (a != 2) aerr = aerr + 1;
        end else if (a == prev + 1) begin
          issued = issued + 1;
        end else if (!(a == prev && a == P_N[g] - 1)) begin
          aerr = aerr + 1;
        end
        prev = a;
      end else begin
        in_run = 1'b0;
      end
    end
    assign issued_v[g] = issued;
    assign aerr_v[g]   = aerr;
  end

  typedef struct {
    int idx;
    int exp_cnt;
    int exp_bcd;
    int exp_ovf;
    int exp_lat;
  } vec_t;

  vec_t vecs[$];

  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Raise start, count posedges from the sampling edge until done is seen.
  task automatic run(input int i, output int lat, output bit ok);
    @(negedge clk);
    start_v[i] = 1'b1;
    @(posedge clk);
    wait_done(i, lat, ok);
  endtask

  task automatic wait_done(input int i, output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      @(posedge clk);
      #1;
      if (done_v[i]) begin
        lat = k;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic stop(input int i);
    @(negedge clk);
    start_v[i] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  ok;
    int  e0;
    int  c, dens, exp_bcd, exp_ovf;

    for (int i = 0; i < NI; i++) begin
      rst_v[i]   = 1'b1;
      start_v[i] = 1'b0;
      for (int a = 0; a < 256; a++)
        mem_v[i][a] = (i == 2 || i == 3 || i == 6) ? 1'b1 : is_prime(a);
    end

    vecs.push_back('{0, 11, 'h11, 0, 52});   // N=32 sieve
    vecs.push_back('{1, 25, 'h25, 0, 120});  // N=100 sieve
    vecs.push_back('{2, 14, 'h14, 0, 36});   // N=16 all ones
    vecs.push_back('{3, 14, 'h14, 0, 37});   // N=16 all ones, RD_LAT=2
    vecs.push_back('{4, 0,  'h0,  0, 21});   // N=2, straight to CONV
    vecs.push_back('{5, 11, 'h9,  1, 52});   // ND=1 overflow
    vecs.push_back('{6, 15, 'h15, 0, 44});   // CW=4 saturates at 15

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("reset_state", i,
          {busy_v[i], done_v[i], ovf_v[i], cnt_v[i], bcd_v[i][27:0]}, 64'd0);
      chk("reset_addr", i, addr_v[i], 0);
    end
    for (int i = 0; i < NI; i++) rst_v[i] = 1'b0;

    foreach (vecs[v]) begin
      int i;
      i  = vecs[v].idx;
      e0 = aerr_v[i];
      run(i, lat, ok);
      chk("done_seen", i, ok, 1);
      chk("latency", i, lat, vecs[v].exp_lat);
      chk("prime_cnt", i, cnt_v[i], vecs[v].exp_cnt);
      chk("bcd", i, bcd_v[i], vecs[v].exp_bcd);
      chk("ovf", i, ovf_v[i], vecs[v].exp_ovf);
      if (P_N[i] > 2) begin
        chk("addr_issued", i, issued_v[i], P_N[i] - 2);
        chk("addr_errors", i, aerr_v[i] - e0, 0);
      end else begin
        chk("addr_untouched", i, addr_v[i], 0);
      end
      stop(i);
      chk("back_idle", i, {done_v[i], busy_v[i]}, 0);
      chk("cnt_held", i, cnt_v[i], vecs[v].exp_cnt);
    end

    // Reset 20 cycles into SCAN with start held high, then re-run.
    @(negedge clk);
    start_v[1] = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
    chk("midscan_busy", 1, busy_v[1], 1);
    @(negedge clk);
    rst_v[1] = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_outputs", 1,
          {busy_v[1], done_v[1], ovf_v[1], cnt_v[1], bcd_v[1][27:0]}, 64'd0);
      chk("rst_addr", 1, addr_v[1], 0);
    end
    @(negedge clk);
    e0 = aerr_v[1];
    rst_v[1] = 1'b0;
    @(posedge clk);
    wait_done(1, lat, ok);
    chk("rerun_done", 1, ok, 1);
    chk("rerun_latency", 1, lat, 120);
    chk("rerun_cnt", 1, cnt_v[1], 25);
    chk("rerun_bcd", 1, bcd_v[1], 'h25);
    chk("rerun_addr_errors", 1, aerr_v[1] - e0, 0);
    stop(1);
    chk("drop_idle", 1, {done_v[1], busy_v[1]}, 0);
    chk("drop_held_bcd", 1, bcd_v[1], 'h25);
    run(1, lat, ok);
    chk("again_cnt", 1, cnt_v[1], 25);
    chk("again_latency", 1, lat, 120);
    stop(1);

    // Random RAM contents against a counting model.
    for (int r = 0; r < 10; r++) begin
      dens = (r == 0) ? 100 : (r == 1) ? 0 : int'($urandom_range(0, 100));
      c = 0;
      for (int a = 0; a < 256; a++) begin
        mem_v[RI][a] = ($urandom_range(0, 99) < dens);
        if (a >= 2 && a <= P_N[RI] - 1 && mem_v[RI][a]) c++;
      end
      exp_ovf = (c >= 100) ? 1 : 0;
      exp_bcd = exp_ovf ? 'h99 : (((c / 10) << 4) | (c % 10));
      run(RI, lat, ok);
      chk("rnd_done", RI, ok, 1);
      chk("rnd_latency", RI, lat, (P_N[RI] - 2) + P_L[RI] + P_CW[RI] + 1);
      chk("rnd_cnt", RI, cnt_v[RI], c);
      chk("rnd_bcd", RI, bcd_v[RI], exp_bcd);
      chk("rnd_ovf", RI, ovf_v[RI], exp_ovf);
      stop(RI);
    end
    chk("rnd_addr_errors", RI, aerr_v[RI], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
